// File: rtl/gate_check_pkg.sv
// Shared definitions for the exhaustive gate checker.
//   state_t      : checker FSM states (IDLE, SETTLE, CHECK, DONE)
//   TT_*         : truth tables for common 2-input gates; bit i is the
//                  expected gate output when the stimulus equals i
//                  (bit 0 = A, bit 1 = B).
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_truth_table_checker.sv
// Exhaustive on-chip checker for a small combinational gate.
// Sweeps stim through 0 .. 2^N_INPUTS-1, holds each vector for
// SETTLE_CYCLES cycles, then spends one CHECK cycle comparing dut_out with
// TRUTH_TABLE[stim]. Reports error count, first failing vector and pass.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (overrides start)
//   start        in   begin a sweep; honoured only in IDLE or DONE
//   dut_out      in   gate-under-test output, sampled at the CHECK edge only
//   stim         out  registered gate inputs (bit 0 = A, bit 1 = B, ...)
//   busy         out  sweep in progress (SETTLE or CHECK)
//   done         out  sweep complete, held until next start or rst
//   pass         out  done and no mismatches
//   err_count    out  number of mismatching vectors
//   fail_valid   out  at least one mismatch recorded
//   fail_vector  out  stim value of the first mismatch
//   state_dbg    out  current FSM state, for observation only
//
// Handshake: start is a level sampled on each rising edge; it launches a
// sweep only when the FSM is in IDLE or DONE and is ignored otherwise.
// done stays high in DONE; results are stable there until the next start.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int                         N_INPUTS      = 2,
  parameter logic [2**N_INPUTS-1:0]     TRUTH_TABLE   = TT_AND2,
  parameter int                         SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_out,
  output logic [N_INPUTS-1:0]   stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_INPUTS:0]     err_count,
  output logic                  fail_valid,
  output logic [N_INPUTS-1:0]   fail_vector,
  output state_t                state_dbg
);

  localparam int                  CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] STIM_LAST  = '1;

  state_t                r_state;
  state_t                w_next_state;
  logic [N_INPUTS-1:0]   r_stim;
  logic [CNT_W-1:0]      r_cnt;
  logic [N_INPUTS:0]     r_err_count;
  logic                  r_fail_valid;
  logic [N_INPUTS-1:0]   r_fail_vector;
  logic                  w_mismatch;

  // Only meaningful in CHECK; dut_out is a don't-care in every other state.
  assign w_mismatch = (r_state == CHECK) && (dut_out != TRUTH_TABLE[r_stim]);

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_stim        <= '0;
      r_cnt         <= '0;
      r_err_count   <= '0;
      r_fail_valid  <= 1'b0;
      r_fail_vector <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_stim        <= '0;
            r_cnt         <= CNT_RELOAD;
            r_err_count   <= '0;
            r_fail_valid  <= 1'b0;
            r_fail_vector <= '0;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + 1'b1;
            if (!r_fail_valid) begin
              r_fail_valid  <= 1'b1;
              r_fail_vector <= r_stim;
            end
          end
          // The last vector leaves stim in place rather than wrapping to 0.
          if (r_stim != STIM_LAST) begin
            r_stim <= r_stim + 1'b1;
            r_cnt  <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SETTLE;
      SETTLE:  if (r_cnt == '0) w_next_state = CHECK;
      CHECK:   w_next_state = (r_stim == STIM_LAST) ? DONE : SETTLE;
      DONE:    if (start) w_next_state = SETTLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    stim        = r_stim;
    busy        = (r_state == SETTLE) || (r_state == CHECK);
    done        = (r_state == DONE);
    pass        = (r_state == DONE) && (r_err_count == '0);
    err_count   = r_err_count;
    fail_valid  = r_fail_valid;
    fail_vector = r_fail_vector;
    state_dbg   = r_state;
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker. Three checker instances:
//   A: defaults (2-input, TT_AND2, settle 2); gate is AND or tied-1 (mode_a)
//   B: 2-input, TT_OR2, settle 2; gate is AND
//   C: 3-input, 8'b1000_0000, settle 1; gate is 3-input AND
// A cycle-level model derived from the sweep timing rules predicts every
// output each cycle; directed literal checks pin key results.
module tb_gate_truth_table_checker;
  import gate_check_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start = 3'b000;
  logic       mode_a = 1'b0;

  // ---------------- instance A ----------------
  logic [1:0] stim_a, fvec_a;
  logic       busy_a, done_a, pass_a, fval_a, dout_a;
  logic [2:0] err_a;
  state_t     st_a;
  assign dout_a = mode_a ? 1'b1 : (&stim_a);

  gate_truth_table_checker u_a (
    .clk(clk), .rst(rst), .start(start[0]), .dut_out(dout_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fval_a), .fail_vector(fvec_a),
    .state_dbg(st_a));

  // ---------------- instance B ----------------
  logic [1:0] stim_b, fvec_b;
  logic       busy_b, done_b, pass_b, fval_b, dout_b;
  logic [2:0] err_b;
  state_t     st_b;
  assign dout_b = &stim_b;

  gate_truth_table_checker #(.N_INPUTS(2), .TRUTH_TABLE(TT_OR2), .SETTLE_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .dut_out(dout_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fval_b), .fail_vector(fvec_b),
    .state_dbg(st_b));

  // ---------------- instance C ----------------
  logic [2:0] stim_c, fvec_c;
  logic       busy_c, done_c, pass_c, fval_c, dout_c;
  logic [3:0] err_c;
  state_t     st_c;
  assign dout_c = &stim_c;

  gate_truth_table_checker #(.N_INPUTS(3), .TRUTH_TABLE(8'b1000_0000), .SETTLE_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .dut_out(dout_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .fail_valid(fval_c), .fail_vector(fvec_c),
    .state_dbg(st_c));

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err;
    logic       fval;
    logic [2:0] fvec;
    logic [1:0] st;
  } obs_t;

  int         n_in [3] = '{2, 2, 3};
  int         s_cyc[3] = '{2, 2, 1};
  logic [7:0] tt   [3] = '{8'h08, 8'h0E, 8'h80};
  logic [7:0] g_snap[3] = '{8'h08, 8'h08, 8'h80};
  int         k    [3] = '{-1, -1, -1};
  bit         model_live = 1'b0;

  function automatic int sweep_len(input int i);
    return (1 << n_in[i]) * (s_cyc[i] + 1);
  endfunction

  // k = rising edges since the sweep-launching edge (k = 0 right after it),
  // -1 when idle after reset. Vector j is judged at edge (j+1)*(s+1).
  function automatic obs_t predict(input int i);
    obs_t e;
    int   v, t, sv, err, first;
    e = '0;
    v = 1 << n_in[i];
    t = sweep_len(i);
    if (k[i] < 0) begin
      e.st = IDLE;
      return e;
    end
    sv = k[i] / (s_cyc[i] + 1);
    if (sv > v - 1) sv = v - 1;
    err = 0;
    first = -1;
    for (int j = 0; j < v; j++) begin
      if ((j + 1) * (s_cyc[i] + 1) <= k[i] && tt[i][j] != g_snap[i][j]) begin
        err++;
        if (first < 0) first = j;
      end
    end
    e.stim = 3'(sv);
    e.busy = (k[i] < t);
    e.done = (k[i] >= t);
    e.pass = e.done && (err == 0);
    e.err  = 4'(err);
    e.fval = (err > 0);
    e.fvec = (first < 0) ? 3'd0 : 3'(first);
    if (e.done)                               e.st = DONE;
    else if (k[i] % (s_cyc[i] + 1) == s_cyc[i]) e.st = CHECK;
    else                                      e.st = SETTLE;
    return e;
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    o = '0;
    case (i)
      0: begin
        o.stim = 3'(stim_a); o.busy = busy_a; o.done = done_a; o.pass = pass_a;
        o.err = 4'(err_a); o.fval = fval_a; o.fvec = 3'(fvec_a); o.st = st_a;
      end
      1: begin
        o.stim = 3'(stim_b); o.busy = busy_b; o.done = done_b; o.pass = pass_b;
        o.err = 4'(err_b); o.fval = fval_b; o.fvec = 3'(fvec_b); o.st = st_b;
      end
      default: begin
        o.stim = stim_c; o.busy = busy_c; o.done = done_c; o.pass = pass_c;
        o.err = err_c; o.fval = fval_c; o.fvec = fvec_c; o.st = st_c;
      end
    endcase
    return o;
  endfunction

  always @(posedge clk) begin
    model_live <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        k[i] <= -1;
      end else if (start[i] && (k[i] < 0 || k[i] >= sweep_len(i))) begin
        k[i] <= 0;
        if (i == 0) g_snap[0] <= mode_a ? 8'h0F : 8'h08;
      end else if (k[i] >= 0 && k[i] < sweep_len(i)) begin
        k[i] <= k[i] + 1;
      end
    end
  end

  // Compare process: every output of every instance, every cycle.
  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < 3; i++) begin
        obs_t a, e;
        string p;
        a = observe(i);
        e = predict(i);
        p = $sformatf("cyc_%0d", i);
        cmp({p, "_stim"}, 32'(a.stim), 32'(e.stim));
        cmp({p, "_busy"}, 32'(a.busy), 32'(e.busy));
        cmp({p, "_done"}, 32'(a.done), 32'(e.done));
        cmp({p, "_pass"}, 32'(a.pass), 32'(e.pass));
        cmp({p, "_err"},  32'(a.err),  32'(e.err));
        cmp({p, "_fval"}, 32'(a.fval), 32'(e.fval));
        cmp({p, "_fvec"}, 32'(a.fvec), 32'(e.fvec));
        cmp({p, "_state"}, 32'(a.st),  32'(e.st));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks begin and end 1 time unit after a rising edge.
  function automatic logic done_of(input int i);
    case (i)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int i, input int budget, output int cyc);
    cyc = 0;
    while (!done_of(i) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_of(i)) cmp($sformatf("timeout_done_%0d", i), 32'd0, 32'd1);
  endtask

  task automatic sweep(input int i, output int cyc);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    wait_done(i, 60, cyc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int guard;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp("rst_stim", 32'(stim_a), 32'd0);
    cmp("rst_busy", 32'(busy_a), 32'd0);
    cmp("rst_done", 32'(done_a), 32'd0);
    cmp("rst_err",  32'(err_a),  32'd0);

    // AND gate, AND table: clean pass in 12 edges.
    sweep(0, cyc);
    cmp("and_latency", 32'(cyc), 32'd12);
    cmp("and_pass",    32'(pass_a), 32'd1);
    cmp("and_err",     32'(err_a),  32'd0);
    cmp("and_fval",    32'(fval_a), 32'd0);
    repeat (3) @(posedge clk); #1;
    cmp("and_done_held", 32'(done_a), 32'd1);

    // Output tied high against AND table: vectors 0,1,2 fail.
    mode_a = 1'b1;
    sweep(0, cyc);
    cmp("tie1_err",  32'(err_a),  32'd3);
    cmp("tie1_fval", 32'(fval_a), 32'd1);
    cmp("tie1_fvec", 32'(fvec_a), 32'd0);
    cmp("tie1_pass", 32'(pass_a), 32'd0);

    // AND gate checked against OR table: vectors 1,2 fail.
    sweep(1, cyc);
    cmp("or_err",  32'(err_b),  32'd2);
    cmp("or_fvec", 32'(fvec_b), 32'd1);
    cmp("or_pass", 32'(pass_b), 32'd0);

    // start held high: one sweep, then an immediate restart from DONE.
    start[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 60, cyc);
    cmp("hold_latency", 32'(cyc), 32'd12);
    cmp("hold_err_first", 32'(err_a), 32'd3);
    @(posedge clk); #1;
    cmp("hold_restart_done", 32'(done_a), 32'd0);
    cmp("hold_restart_stim", 32'(stim_a), 32'd0);
    cmp("hold_restart_err",  32'(err_a),  32'd0);
    cmp("hold_restart_busy", 32'(busy_a), 32'd1);
    repeat (4) @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, 60, cyc);
    cmp("hold_second_err", 32'(err_a), 32'd3);

    // Reset while stim = 2 in SETTLE aborts the sweep.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (!(stim_a == 2'd2 && st_a == SETTLE) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    cmp("abort_reached", 32'(stim_a), 32'd2);
    cmp("abort_pre_err", 32'(err_a),  32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("abort_stim", 32'(stim_a), 32'd0);
    cmp("abort_busy", 32'(busy_a), 32'd0);
    cmp("abort_done", 32'(done_a), 32'd0);
    cmp("abort_err",  32'(err_a),  32'd0);
    mode_a = 1'b0;
    sweep(0, cyc);
    cmp("post_abort_latency", 32'(cyc), 32'd12);
    cmp("post_abort_pass",    32'(pass_a), 32'd1);

    // 3-input AND, settle 1: 8 vectors x 2 cycles.
    sweep(2, cyc);
    cmp("and3_latency", 32'(cyc), 32'd16);
    cmp("and3_pass",    32'(pass_c), 32'd1);
    cmp("and3_stim",    32'(stim_c), 32'd7);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Synthesizable on-chip exhaustive checker for small combinational gates in the gate library (AND, OR, XOR, ...).
- Acts as the hardware counterpart of a gate testbench:
  - drives every input combination into a DUT gate;
  - waits a settle interval;
  - samples the DUT output and compares it against a parameterised truth table.
- Reports pass/fail, error count and the first failing vector.
- Sits beside the gate under test on FPGA bring-up boards and in regression top-levels.

Parameters:
- N_INPUTS, 2, number of DUT inputs; vectors swept 0 .. 2^N_INPUTS-1.
- TRUTH_TABLE, 4'b1000, expected output per vector; bit i = expected output for stim == i. Width 2^N_INPUTS. Default is 2-input AND.
- SETTLE_CYCLES, 2, cycles stim is held before sampling; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_out  in  1  output of gate under test.
- stim  out  N_INPUTS  inputs to gate under test; bit 0 = A, bit 1 = B, ...
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until next start or rst.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  N_INPUTS+1  number of mismatching vectors; saturation is impossible by sizing.
- fail_valid  out  1  at least one mismatch recorded.
- fail_vector  out  N_INPUTS  stim value of the first mismatch.

Behaviour:
- Reset (synchronous, rst high at a rising clk edge):
  - state = IDLE; stim = 0; busy = 0; done = 0; pass = 0; err_count = 0; fail_valid = 0; fail_vector = 0.
  - rst overrides start.
  - rst mid-sweep aborts immediately, with no done pulse.
- States:
  - IDLE: start=1 -> SETTLE. On that edge: stim = 0, settle counter = SETTLE_CYCLES-1, err_count/fail_* cleared, busy = 1.
  - SETTLE: counter decrements each cycle; stim held. Counter == 0 -> CHECK. Lasts exactly SETTLE_CYCLES cycles.
  - CHECK: one cycle. At the closing edge, compare dut_out with TRUTH_TABLE[stim].
    - Mismatch: err_count += 1. If fail_valid == 0, fail_vector = stim and fail_valid = 1.
    - stim != 2^N_INPUTS-1: stim += 1, counter reloaded, -> SETTLE.
    - stim == all ones: -> DONE; stim stays at its last value, no wrap.
  - DONE: done = 1; busy = 0; pass = (final err_count == 0), including the last vector's result. start=1 -> restart exactly as from IDLE; done/pass drop on that edge.
- start while busy is ignored and has no effect on stim or counters.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - If start is sampled at edge e0, done is first high after edge e0 + 2^N_INPUTS*(SETTLE_CYCLES+1). With defaults that is e0+12.
- stim is registered, so there is no glitch within a vector.
- dut_out is sampled only at the CHECK closing edge; other values are don't-care.
- err_count and fail_* are stable and readable in DONE until the next start or rst.

Decomposition:
- Shared package gate_check_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - truth-table constants TT_AND2 = 4'b1000, TT_OR2 = 4'b1110, TT_XOR2 = 4'b0110, TT_NAND2 = 4'b0111, TT_NOR2 = 4'b0001.
- Single module, no sub-module: the settle counter and vector counter are trivial and inline.

Test Plan:
- AND gate DUT, defaults; rst 2 cycles, start pulse -> stim steps 0,1,2,3 every 3 cycles; done after 12 edges; pass=1, err_count=0, fail_valid=0.
- DUT output tied to 1, TRUTH_TABLE=TT_AND2 -> err_count=3, fail_valid=1, fail_vector=0, pass=0.
- AND DUT with TRUTH_TABLE=TT_OR2 -> err_count=2, fail_vector=1, pass=0.
- start asserted continuously during a sweep -> sweep completes once in 12 cycles; then, still high in DONE, a fresh sweep starts with stim=0, done=0, err_count cleared.
- rst asserted while stim=2 in SETTLE -> next edge: stim=0, busy=0, done=0, err_count=0; a new start gives a full clean sweep.
- SETTLE_CYCLES=1, N_INPUTS=3, 3-input AND DUT with TRUTH_TABLE=8'b1000_0000 -> done after 16 edges, pass=1.
